// File: rtl/mux_share_arbiter.sv
// Two-requester round-robin arbiter that drives the select of a 2:1 data mux and registers the chosen data.
// Grant appears one edge after the request; d_out/d_valid follow the grant by one further edge.
// A holder is rotated out after MAX_HOLD cycles only while the other side is waiting.
module mux_share_arbiter #(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req1,
    input  logic          req2,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    output logic          gnt1,
    output logic          gnt2,
    output logic          sel,
    output logic [DW-1:0] d_out,
    output logic          d_valid
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          last2_q, last2_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dvld_q, dvld_d;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last2_d = last2_q;
        dout_d  = dout_q;
        dvld_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req1 && req2) begin
                    state_d = last2_q ? GRANT1 : GRANT2;
                end else if (req1) begin
                    state_d = GRANT1;
                end else if (req2) begin
                    state_d = GRANT2;
                end
            end
            GRANT1: begin
                dout_d = d1;
                dvld_d = 1'b1;
                if (!req1) begin
                    state_d = req2 ? GRANT2 : IDLE;
                end else if (req2 && (hold_q == HOLD_MAX)) begin
                    state_d = GRANT2;
                end
            end
            GRANT2: begin
                dout_d = d2;
                dvld_d = 1'b1;
                if (!req2) begin
                    state_d = req1 ? GRANT1 : IDLE;
                end else if (req1 && (hold_q == HOLD_MAX)) begin
                    state_d = GRANT1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh owner starts its hold count at 1; a continuing owner saturates.
        if (state_d == IDLE) begin
            hold_d = '0;
        end else if (state_d != state_q) begin
            hold_d  = HW'(1);
            last2_d = (state_d == GRANT2);
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            last2_q <= 1'b1;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last2_q <= last2_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
        end
    end

    assign gnt1    = (state_q == GRANT1);
    assign gnt2    = (state_q == GRANT2);
    assign sel     = (state_q == GRANT2);
    assign d_out   = dout_q;
    assign d_valid = dvld_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Randomized and directed bench for mux_share_arbiter with a queue-based scoreboard.
module tb_mux_share_arbiter;

    localparam int DW       = 1;
    localparam int MAX_HOLD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req1, req2;
    logic [DW-1:0] d1, d2;
    logic          gnt1, gnt2, sel, d_valid;
    logic [DW-1:0] d_out;

    mux_share_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req1   (req1),
        .req2   (req2),
        .d1     (d1),
        .d2     (d2),
        .gnt1   (gnt1),
        .gnt2   (gnt2),
        .sel    (sel),
        .d_out  (d_out),
        .d_valid(d_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          g1;
        logic          g2;
        logic          s;
        logic [DW-1:0] dout;
        logic          dv;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the path, how long it has held it, who was served last.
    int            m_owner = 0;
    int            m_run   = 0;
    int            m_last  = 2;
    logic [DW-1:0] m_dout  = '0;
    logic          m_dv    = 1'b0;

    function automatic obs_t model_obs();
        obs_t o;
        o.g1   = (m_owner == 1);
        o.g2   = (m_owner == 2);
        o.s    = (m_owner == 2);
        o.dout = m_dout;
        o.dv   = m_dv;
        return o;
    endfunction

    always @(negedge rst_n) begin
        m_owner = 0; m_run = 0; m_last = 2; m_dout = '0; m_dv = 1'b0;
        exp_q.delete();
    end

    always @(posedge clk) begin
        int want, mine, theirs, other;
        if (!rst_n) begin
            m_owner = 0; m_run = 0; m_last = 2; m_dout = '0; m_dv = 1'b0;
        end else begin
            if (m_owner != 0) begin
                m_dout = (m_owner == 1) ? d1 : d2;
                m_dv   = 1'b1;
            end else begin
                m_dv = 1'b0;
            end
            if (m_owner == 0) begin
                if (req1 && req2) want = (m_last == 1) ? 2 : 1;
                else if (req1)    want = 1;
                else if (req2)    want = 2;
                else              want = 0;
            end else begin
                other  = 3 - m_owner;
                mine   = (m_owner == 1) ? int'(req1) : int'(req2);
                theirs = (m_owner == 1) ? int'(req2) : int'(req1);
                if (mine == 0)                          want = (theirs != 0) ? other : 0;
                else if (theirs != 0 && m_run >= MAX_HOLD) want = other;
                else                                    want = m_owner;
            end
            if (want == 0) begin
                m_run = 0;
            end else if (want != m_owner) begin
                m_run  = 1;
                m_last = want;
            end else if (m_run < MAX_HOLD) begin
                m_run = m_run + 1;
            end
            m_owner = want;
        end
        exp_q.push_back(model_obs());
    end

    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{g1: gnt1, g2: gnt2, s: sel, dout: d_out, dv: d_valid};
            chk("outputs{gnt1,gnt2,sel,d_out,d_valid}", 32'(a), 32'(e));
            chk("gnt_exclusive", 32'(gnt1 & gnt2), 32'd0);
        end
    end

    task automatic drive(input logic r1, input logic r2, input logic [DW-1:0] x1,
                         input logic [DW-1:0] x2, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            req1 = r1; req2 = r2; d1 = x1; d2 = x2;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req1 = 1'b0; req2 = 1'b0; d1 = '0; d2 = '0;
        #1;
        chk("reset_gnt1", 32'(gnt1), 32'd0);
        chk("reset_gnt2", 32'(gnt2), 32'd0);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_dvalid", 32'(d_valid), 32'd0);
        chk("reset_dout", 32'(d_out), 32'd0);

        // Contention straight out of reset: 4/4 rotation, requester 1 first.
        req1 = 1'b1; req2 = 1'b1;
        #21 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, DW'($urandom), DW'($urandom), 1);

        // Single request, then release.
        drive(1'b0, 1'b0, '0, '0, 3);
        drive(1'b1, 1'b0, DW'(1), '0, 4);
        drive(1'b0, 1'b0, '0, '0, 3);

        // Early release: requester 1 drops after 2 grant cycles while 2 waits.
        drive(1'b1, 1'b0, '0, '0, 1);
        drive(1'b1, 1'b1, '0, DW'(1), 1);
        drive(1'b0, 1'b1, '0, DW'(1), 3);
        drive(1'b0, 1'b0, '0, '0, 3);

        // Saturation: requester 1 alone, late request from 2.
        drive(1'b1, 1'b0, DW'(1), '0, 7);
        drive(1'b1, 1'b1, DW'(1), '0, 3);
        drive(1'b0, 1'b0, '0, '0, 3);

        // Data steering: d1 toggles while requester 2 owns the path.
        drive(1'b0, 1'b1, '0, '0, 2);
        drive(1'b0, 1'b1, DW'(1), '0, 1);
        drive(1'b0, 1'b1, DW'(0), DW'(1), 1);
        drive(1'b0, 1'b1, DW'(1), '0, 1);
        drive(1'b0, 1'b0, '0, '0, 3);

        // Async reset while GRANT2 holds d_out=1.
        drive(1'b0, 1'b1, '0, DW'(1), 4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt2", 32'(gnt2), 32'd0);
        chk("async_sel", 32'(sel), 32'd0);
        chk("async_dout", 32'(d_out), 32'd0);
        chk("async_dvalid", 32'(d_valid), 32'd0);
        req1 = 1'b1; req2 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_first_gnt1", 32'(gnt1), 32'd1);
        drive(1'b1, 1'b1, '0, '0, 10);

        // Random traffic with bursty request patterns.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  DW'($urandom), DW'($urandom), 1);
        end
        drive(1'b0, 1'b0, '0, '0, 3);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
